// File: rtl/cve2_xif_copro_pkg.sv
// Shared definitions for the CV-X-IF MAC coprocessor: custom-0 opcode,
// operation encoding, FSM states and the instruction decoder.
package cve2_xif_copro_pkg;

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

  typedef enum logic [2:0] {
    OP_MAC    = 3'b000,
    OP_ACC_RD = 3'b001,
    OP_ACC_WR = 3'b010,
    OP_ADD3   = 3'b011,
    OP_CNT_RD = 3'b100
  } copro_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_COMMIT,
    ST_EXEC,
    ST_RESULT
  } copro_state_e;

  typedef struct packed {
    logic       accept;
    logic       writeback;
    logic [2:0] register_read;
    copro_op_e  op;
  } copro_dec_t;

  // ADD3 is R4-type: instr[31:27] names rs3 and funct2 is ignored, so it
  // is the only op that does not require funct7 == 0.
  function automatic copro_dec_t copro_decode(input logic [31:0] instr,
                                              input logic        perf_en);
    copro_dec_t dec;
    logic       f7_zero;
    dec     = '0;
    f7_zero = (instr[31:25] == 7'h00);
    if (instr[6:0] == OPCODE_CUSTOM0) begin
      case (instr[14:12])
        3'b000: if (f7_zero) begin
          dec.accept = 1'b1; dec.writeback = 1'b1;
          dec.register_read = 3'b011; dec.op = OP_MAC;
        end
        3'b001: if (f7_zero) begin
          dec.accept = 1'b1; dec.writeback = 1'b1;
          dec.register_read = 3'b000; dec.op = OP_ACC_RD;
        end
        3'b010: if (f7_zero) begin
          dec.accept = 1'b1; dec.writeback = 1'b0;
          dec.register_read = 3'b001; dec.op = OP_ACC_WR;
        end
        3'b011: begin
          dec.accept = 1'b1; dec.writeback = 1'b1;
          dec.register_read = 3'b111; dec.op = OP_ADD3;
        end
        3'b100: if (f7_zero && perf_en) begin
          dec.accept = 1'b1; dec.writeback = 1'b1;
          dec.register_read = 3'b000; dec.op = OP_CNT_RD;
        end
        default: ;
      endcase
    end
    return dec;
  endfunction

endpackage

// File: rtl/cve2_xif_copro_mul.sv
// 32x32 -> low 32 multiplier with start/done. FastMul=1 answers in the
// start cycle; FastMul=0 runs a 32-cycle shift-add, done in the last cycle.
module cve2_xif_copro_mul #(
  parameter bit FastMul = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        done_o,
  output logic [31:0] product_o
);

  if (FastMul) begin : g_fast
    logic unused_fast;
    assign unused_fast = clk_i ^ rst_ni;
    assign done_o      = start_i;
    assign product_o   = a_i * b_i;
  end else begin : g_iter
    logic [31:0] mcand_q, mplier_q, sum_q;
    logic [4:0]  cnt_q;
    logic        busy_q;

    // one partial product per cycle; the 32nd is folded into product_o
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        mcand_q  <= '0;
        mplier_q <= '0;
        sum_q    <= '0;
        cnt_q    <= '0;
        busy_q   <= 1'b0;
      end else if (start_i) begin
        mcand_q  <= a_i;
        mplier_q <= b_i;
        sum_q    <= '0;
        cnt_q    <= 5'd31;
        busy_q   <= 1'b1;
      end else if (busy_q) begin
        if (cnt_q == 5'd0) begin
          busy_q <= 1'b0;
        end else begin
          sum_q    <= sum_q + (mplier_q[0] ? mcand_q : 32'h0);
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - 5'd1;
        end
      end
    end

    assign done_o    = busy_q && (cnt_q == 5'd0);
    assign product_o = sum_q + (mplier_q[0] ? mcand_q : 32'h0);
  end

endmodule

// File: rtl/cve2_xif_mac_copro.sv
// CV-X-IF reference coprocessor: accepts custom-0 MAC / ACC_RD / ACC_WR /
// ADD3, executes them after commit and returns results.
// Optional macro CVE2_XIF_COPRO_PERF_EN adds a committed-instruction
// counter readable via funct3 100 (CNT_RD).
//
// state          | meaning
// ST_IDLE        | ready for issue, no instruction in flight
// ST_WAIT_COMMIT | accepted, waiting for commit or kill
// ST_EXEC        | iterative multiply running
// ST_RESULT      | result offered until the core takes it
module cve2_xif_mac_copro
  import cve2_xif_copro_pkg::*;
#(
  parameter bit          FastMul     = 1'b0,
  parameter logic [31:0] AccResetVal = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        xif_issue_valid_i,
  input  logic [31:0] xif_issue_req_instr_i,
  output logic        xif_issue_ready_o,
  output logic        xif_issue_resp_accept_o,
  output logic        xif_issue_resp_writeback_o,
  output logic [2:0]  xif_issue_resp_register_read_o,
  input  logic [31:0] xif_register_rs1_i,
  input  logic [31:0] xif_register_rs2_i,
  input  logic [31:0] xif_register_rs3_i,
  input  logic [2:0]  xif_register_rs_valid_i,
  input  logic        xif_commit_valid_i,
  input  logic        xif_commit_kill_i,
  output logic        xif_result_valid_o,
  input  logic        xif_result_ready_i,
  output logic        xif_result_we_o,
  output logic [31:0] xif_result_data_o
);

  copro_state_e state_q;
  copro_op_e    op_q;
  copro_dec_t   dec;
  logic         wb_q;
  logic [31:0]  rs1_q, rs2_q, rs3_q, acc_q;
  logic         res_valid_q, res_we_q;
  logic [31:0]  res_data_q;
  logic         issue_hs, commit_go, mul_start, mul_done;
  logic [31:0]  mul_product, mac_sum, perf_cnt;
  logic         unused_instr;

`ifdef CVE2_XIF_COPRO_PERF_EN
  localparam logic PerfEn = 1'b1;
  logic [31:0] perf_cnt_q;

  // counts every commit that is not killed; wraps at 2^32
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        perf_cnt_q <= '0;
    else if (commit_go) perf_cnt_q <= perf_cnt_q + 32'd1;
  end
  assign perf_cnt = perf_cnt_q;
`else
  localparam logic PerfEn = 1'b0;
  assign perf_cnt = 32'h0;
`endif

  assign dec          = copro_decode(xif_issue_req_instr_i, PerfEn);
  assign unused_instr = ^{xif_issue_req_instr_i[24:15], xif_issue_req_instr_i[11:7]};

  assign xif_issue_resp_accept_o        = xif_issue_valid_i & dec.accept;
  assign xif_issue_resp_writeback_o     = xif_issue_valid_i & dec.writeback;
  assign xif_issue_resp_register_read_o = xif_issue_valid_i ? dec.register_read : 3'b000;
  assign xif_issue_ready_o = xif_issue_valid_i && (state_q == ST_IDLE) &&
                             ((xif_register_rs_valid_i & dec.register_read) == dec.register_read);
  assign issue_hs  = xif_issue_valid_i & xif_issue_ready_o;
  assign commit_go = (state_q == ST_WAIT_COMMIT) & xif_commit_valid_i & ~xif_commit_kill_i;
  assign mul_start = commit_go & (op_q == OP_MAC);
  assign mac_sum   = acc_q + mul_product;

  cve2_xif_copro_mul #(.FastMul(FastMul)) u_mul (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (mul_start),
    .a_i       (rs1_q),
    .b_i       (rs2_q),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  // issue/commit/result sequencing with registered result outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_MAC;
      wb_q        <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rs3_q       <= '0;
      acc_q       <= AccResetVal;
      res_valid_q <= 1'b0;
      res_we_q    <= 1'b0;
      res_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (issue_hs && dec.accept) begin
          op_q    <= dec.op;
          wb_q    <= dec.writeback;
          rs1_q   <= xif_register_rs1_i;
          rs2_q   <= xif_register_rs2_i;
          rs3_q   <= xif_register_rs3_i;
          state_q <= ST_WAIT_COMMIT;
        end
        ST_WAIT_COMMIT: if (xif_commit_valid_i) begin
          if (xif_commit_kill_i) begin
            state_q <= ST_IDLE;
          end else if (op_q == OP_MAC && !mul_done) begin
            state_q <= ST_EXEC;
          end else begin
            res_valid_q <= 1'b1;
            res_we_q    <= wb_q;
            state_q     <= ST_RESULT;
            case (op_q)
              OP_MAC:    begin acc_q <= mac_sum; res_data_q <= mac_sum; end
              OP_ACC_RD: res_data_q <= acc_q;
              OP_ACC_WR: begin acc_q <= rs1_q; res_data_q <= 32'h0; end
              OP_ADD3:   res_data_q <= rs1_q + rs2_q + rs3_q;
              OP_CNT_RD: res_data_q <= perf_cnt;
              default:   res_data_q <= 32'h0;
            endcase
          end
        end
        ST_EXEC: if (mul_done) begin
          acc_q       <= mac_sum;
          res_data_q  <= mac_sum;
          res_valid_q <= 1'b1;
          res_we_q    <= wb_q;
          state_q     <= ST_RESULT;
        end
        ST_RESULT: if (xif_result_ready_i) begin
          res_valid_q <= 1'b0;
          res_we_q    <= 1'b0;
          res_data_q  <= '0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign xif_result_valid_o = res_valid_q;
  assign xif_result_we_o    = res_we_q;
  assign xif_result_data_o  = res_data_q;

endmodule

// File: tb/tb_cve2_xif_mac_copro.sv
// Directed bench for cve2_xif_mac_copro (FastMul=0, AccResetVal=0).
module tb_cve2_xif_mac_copro;

  localparam logic [6:0]  OPC     = 7'b0001011;
  localparam logic [31:0] I_ACCWR = {7'h00, 5'd0, 5'd1, 3'b010, 5'd2, OPC};
  localparam logic [31:0] I_MAC   = {7'h00, 5'd2, 5'd1, 3'b000, 5'd3, OPC};
  localparam logic [31:0] I_ACCRD = {7'h00, 5'd0, 5'd0, 3'b001, 5'd4, OPC};
  localparam logic [31:0] I_ADD3  = {5'd3, 2'b11, 5'd2, 5'd1, 3'b011, 5'd5, OPC};
  localparam logic [31:0] I_CNTRD = {7'h00, 5'd0, 5'd0, 3'b100, 5'd6, OPC};
  localparam logic [31:0] I_MACBAD = {7'h01, 5'd2, 5'd1, 3'b000, 5'd3, OPC};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [31:0] instr;
  logic        issue_ready, accept, writeback;
  logic [2:0]  reg_read;
  logic [31:0] rs1, rs2, rs3;
  logic [2:0]  rs_valid;
  logic        commit_valid, commit_kill;
  logic        result_valid, result_ready, result_we;
  logic [31:0] result_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cve2_xif_mac_copro #(.FastMul(1'b0), .AccResetVal(32'h0)) dut (
    .clk_i                          (clk),
    .rst_ni                         (rst_n),
    .xif_issue_valid_i              (issue_valid),
    .xif_issue_req_instr_i          (instr),
    .xif_issue_ready_o              (issue_ready),
    .xif_issue_resp_accept_o        (accept),
    .xif_issue_resp_writeback_o     (writeback),
    .xif_issue_resp_register_read_o (reg_read),
    .xif_register_rs1_i             (rs1),
    .xif_register_rs2_i             (rs2),
    .xif_register_rs3_i             (rs3),
    .xif_register_rs_valid_i        (rs_valid),
    .xif_commit_valid_i             (commit_valid),
    .xif_commit_kill_i              (commit_kill),
    .xif_result_valid_o             (result_valid),
    .xif_result_ready_i             (result_ready),
    .xif_result_we_o                (result_we),
    .xif_result_data_o              (result_data)
  );

  // Offer an instruction until ready (bounded), handshake on the next edge.
  task automatic drive_issue(input logic [31:0] ins, input logic [31:0] a, b, c,
                             input logic [2:0] rv, output bit ok, output int waited);
    issue_valid = 1'b1; instr = ins; rs1 = a; rs2 = b; rs3 = c; rs_valid = rv;
    ok = 1'b0; waited = 0;
    #1;
    while (issue_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    ok = (issue_ready === 1'b1);
    @(posedge clk); #1;
    issue_valid = 1'b0; rs_valid = 3'b000;
  endtask

  task automatic do_commit(input bit kill);
    commit_valid = 1'b1; commit_kill = kill;
    @(posedge clk); #1;
    commit_valid = 1'b0; commit_kill = 1'b0;
  endtask

  // latency in cycles from the commit cycle to result_valid
  task automatic wait_result(output int lat);
    lat = 1;
    while (result_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic take_result;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  task automatic do_op(input logic [31:0] ins, input logic [31:0] a, b, c, input logic [2:0] rv,
                       output bit ok, output int lat, output logic [31:0] data, output logic we);
    int w;
    drive_issue(ins, a, b, c, rv, ok, w);
    do_commit(1'b0);
    wait_result(lat);
    data = result_data; we = result_we;
    take_result();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; issue_valid = 1'b0; instr = '0; rs1 = '0; rs2 = '0; rs3 = '0;
    rs_valid = '0; commit_valid = 1'b0; commit_kill = 1'b0; result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({result_valid, result_we, result_data, issue_ready, accept, writeback, reg_read} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b we=%b data=%h ready=%b acc=%b, want all 0",
               result_valid, result_we, result_data, issue_ready, accept);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_acc_wr_mac;
    bit ok; int w, lat;
    issue_valid = 1'b1; instr = I_ACCWR; rs_valid = 3'b001;
    #1;
    checks++;
    if ({accept, writeback, reg_read} !== 5'b10001) begin
      failures++;
      $display("FAIL accwr_decode: got acc=%b wb=%b rr=%b, want 1 0 001", accept, writeback, reg_read);
    end
    drive_issue(I_ACCWR, 32'd5, 32'd0, 32'd0, 3'b001, ok, w);
    do_commit(1'b0);
    wait_result(lat);
    checks++;
    if (!ok || lat != 1 || result_we !== 1'b0 || result_data !== 32'h0) begin
      failures++;
      $display("FAIL accwr_result: got ok=%0d lat=%0d we=%b data=%h, want 1 1 0 0", ok, lat, result_we, result_data);
    end
    take_result();
    drive_issue(I_MAC, 32'd3, 32'd4, 32'd0, 3'b011, ok, w);
    do_commit(1'b0);
    wait_result(lat);
    checks++;
    if (!ok || lat != 33) begin
      failures++;
      $display("FAIL mac_latency: got ok=%0d lat=%0d, want 33", ok, lat);
    end
    checks++;
    if (result_data !== 32'd17 || result_we !== 1'b1) begin
      failures++;
      $display("FAIL mac_result: got data=%h we=%b, want 00000011 1", result_data, result_we);
    end
    take_result();
  endtask

  task automatic test_reject;
    bit ok; int w, lat; logic [31:0] d; logic we;
    issue_valid = 1'b1; instr = 32'h00000013; rs_valid = 3'b000;
    #1;
    checks++;
    if (issue_ready !== 1'b1 || accept !== 1'b0 || writeback !== 1'b0 || reg_read !== 3'b000) begin
      failures++;
      $display("FAIL reject_resp: got ready=%b acc=%b wb=%b rr=%b, want 1 0 0 000",
               issue_ready, accept, writeback, reg_read);
    end
    @(posedge clk); #1;
    issue_valid = 1'b0;
    checks++;
    if (result_valid !== 1'b0) begin
      failures++;
      $display("FAIL reject_noresult: got valid=%b, want 0", result_valid);
    end
    drive_issue(I_ACCRD, 32'd0, 32'd0, 32'd0, 3'b000, ok, w);
    checks++;
    if (!ok || w != 0) begin
      failures++;
      $display("FAIL reissue_immediate: got ok=%0d waited=%0d, want 1 0", ok, w);
    end
    do_commit(1'b0);
    wait_result(lat);
    d = result_data; we = result_we;
    take_result();
    checks++;
    if (d !== 32'd17 || we !== 1'b1 || lat != 1) begin
      failures++;
      $display("FAIL accrd_after_reject: got data=%h we=%b lat=%0d, want 00000011 1 1", d, we, lat);
    end
  endtask

  task automatic test_add3;
    int lat;
    issue_valid = 1'b1; instr = I_ADD3;
    rs1 = 32'd1; rs2 = 32'd2; rs3 = 32'hFFFF_FFFF; rs_valid = 3'b011;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (issue_ready !== 1'b0) begin
        failures++;
        $display("FAIL add3_wait_rs3: cycle %0d got ready=%b, want 0", i, issue_ready);
      end
      @(posedge clk); #1;
    end
    rs_valid = 3'b111;
    #1;
    checks++;
    if (issue_ready !== 1'b1 || accept !== 1'b1 || reg_read !== 3'b111) begin
      failures++;
      $display("FAIL add3_ready: got ready=%b acc=%b rr=%b, want 1 1 111", issue_ready, accept, reg_read);
    end
    @(posedge clk); #1;
    issue_valid = 1'b0; rs_valid = 3'b000;
    do_commit(1'b0);
    wait_result(lat);
    checks++;
    if (result_data !== 32'd2 || result_we !== 1'b1 || lat != 1) begin
      failures++;
      $display("FAIL add3_result: got data=%h we=%b lat=%0d, want 00000002 1 1", result_data, result_we, lat);
    end
    take_result();
  endtask

  task automatic test_kill;
    bit ok; int w, lat, seen; logic [31:0] d; logic we;
    drive_issue(I_MAC, 32'd7, 32'd9, 32'd0, 3'b011, ok, w);
    do_commit(1'b1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0 || !ok) begin
      failures++;
      $display("FAIL kill_noresult: got valid cycles=%0d ok=%0d, want 0 1", seen, ok);
    end
    do_op(I_ACCRD, 32'd0, 32'd0, 32'd0, 3'b000, ok, lat, d, we);
    checks++;
    if (d !== 32'd17) begin
      failures++;
      $display("FAIL kill_acc_unchanged: got %h, want 00000011", d);
    end
  endtask

  task automatic test_backpressure;
    bit ok; int w, lat, bad;
    drive_issue(I_ACCRD, 32'd0, 32'd0, 32'd0, 3'b000, ok, w);
    do_commit(1'b0);
    wait_result(lat);
    issue_valid = 1'b1; instr = I_ACCRD; rs_valid = 3'b000;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (result_valid !== 1'b1 || result_data !== 32'd17 || result_we !== 1'b1 || issue_ready !== 1'b0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL backpressure_stable: got %0d bad cycles, want 0", bad);
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release: got valid=%b ready=%b, want 0 1", result_valid, issue_ready);
    end
    @(posedge clk); #1;
    issue_valid = 1'b0;
    do_commit(1'b0);
    wait_result(lat);
    checks++;
    if (result_data !== 32'd17 || lat != 1) begin
      failures++;
      $display("FAIL back_to_back_accrd: got data=%h lat=%0d, want 00000011 1", result_data, lat);
    end
    take_result();
  endtask

  task automatic test_decode_reject;
    logic exp_cnt;
`ifdef CVE2_XIF_COPRO_PERF_EN
    exp_cnt = 1'b1;
`else
    exp_cnt = 1'b0;
`endif
    issue_valid = 1'b1; instr = I_MACBAD; rs_valid = 3'b000;
    #1;
    checks++;
    if (accept !== 1'b0 || reg_read !== 3'b000) begin
      failures++;
      $display("FAIL mac_funct7_reject: got acc=%b rr=%b, want 0 000", accept, reg_read);
    end
    instr = I_CNTRD;
    #1;
    checks++;
    if (accept !== exp_cnt || writeback !== exp_cnt) begin
      failures++;
      $display("FAIL cntrd_decode: got acc=%b wb=%b, want %b %b", accept, writeback, exp_cnt, exp_cnt);
    end
    issue_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_exec;
    bit ok; int w, lat, seen; logic [31:0] d; logic we;
    drive_issue(I_MAC, 32'd2, 32'd3, 32'd0, 3'b011, ok, w);
    do_commit(1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({result_valid, result_we, result_data, issue_ready} !== '0) begin
      failures++;
      $display("FAIL reset_exec_outputs: got valid=%b we=%b data=%h ready=%b, want 0",
               result_valid, result_we, result_data, issue_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_exec_noresult: got %0d valid cycles, want 0", seen);
    end
    do_op(I_ACCRD, 32'd0, 32'd0, 32'd0, 3'b000, ok, lat, d, we);
    checks++;
    if (d !== 32'h0 || !ok) begin
      failures++;
      $display("FAIL reset_exec_acc: got %h ok=%0d, want 00000000 1", d, ok);
    end
  endtask

`ifdef CVE2_XIF_COPRO_PERF_EN
  task automatic test_perf;
    bit ok; int w, lat; logic [31:0] d; logic we;
    for (int i = 0; i < 3; i++) do_op(I_ACCWR, 32'd1, 32'd0, 32'd0, 3'b001, ok, lat, d, we);
    drive_issue(I_MAC, 32'd1, 32'd1, 32'd0, 3'b011, ok, w);
    do_commit(1'b1);
    do_op(I_CNTRD, 32'd0, 32'd0, 32'd0, 3'b000, ok, lat, d, we);
    checks++;
    if (d !== 32'd3 || we !== 1'b1) begin
      failures++;
      $display("FAIL perf_count: got %h we=%b, want 00000003 1", d, we);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_acc_wr_mac();
    test_reject();
    test_add3();
    test_kill();
    test_backpressure();
    test_decode_reject();
    test_reset_exec();
`ifdef CVE2_XIF_COPRO_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cve2_xif_mac_copro.md
Name: cve2_xif_mac_copro

Overview:
CV-X-IF coprocessor: the responder end of the core's issue, register, commit and result interfaces. It decodes custom-0 instructions offered by the core and accepts or rejects them. Accepted instructions execute after commit (multiply-accumulate, accumulator moves, 3-operand add) and return results over the result handshake. It sits beside the core in simulation and FPGA tops as the reference eXtension unit.

Parameters:
FastMul, 1'b0, 1: single-cycle 32x32 multiply; 0: iterative shift-add, 32 EXEC cycles
AccResetVal, 32'h0, accumulator reset value

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
xif_issue_valid_i  in  1  core offers instruction
xif_issue_req_instr_i  in  32  offered instruction
xif_issue_ready_o  out  1  issue handshake completes
xif_issue_resp_accept_o  out  1  instruction is ours
xif_issue_resp_writeback_o  out  1  result writes rd
xif_issue_resp_register_read_o  out  3  rs1/rs2/rs3 needed (bit0=rs1)
xif_register_rs1_i / rs2_i / rs3_i  in  32 each  operand values
xif_register_rs_valid_i  in  3  operand valid bits
xif_commit_valid_i  in  1  commit/kill decision valid
xif_commit_kill_i  in  1  1 = drop the instruction
xif_result_valid_o  out  1  result available
xif_result_ready_i  in  1  core takes result
xif_result_we_o  out  1  write rd
xif_result_data_o  out  32  result value

Behaviour:
- Clock clk_i, reset rst_ni: asynchronous, active-low. Reset: all outputs 0, state IDLE, acc=AccResetVal, counters 0. Reset mid-operation aborts with no result.
- Decode (combinational, from instr): opcode 7'b0001011, funct7 instr[31:25]=0 except ADD3.
  - funct3 000 MAC: acc+=rs1*rs2 (mod 2^32), rd=new acc; read 011, wb 1.
  - 001 ACC_RD: rd=acc; read 000, wb 1.
  - 010 ACC_WR: acc=rs1; read 001, wb 0.
  - 011 ADD3 (R4, rs3=instr[31:27], funct2 ignored): rd=rs1+rs2+rs3 mod 2^32; read 111, wb 1.
  - Anything else: accept=0, wb=0, read=000.
- Issue: accept/writeback/register_read outputs are driven from the decode whenever issue_valid_i=1; 0 otherwise.
  - issue_ready_o=1 only in IDLE, and only when (rs_valid & register_read)==register_read.
  - Handshake = valid&&ready. Rejected: handshake completes, state stays IDLE.
  - Accepted: latch op and operands; go to WAIT_COMMIT.
- WAIT_COMMIT: issue_ready_o=0; commit sampled only here, so the earliest commit is the cycle after issue.
  - kill=1: back to IDLE, no result, acc unchanged.
  - kill=0: MAC with FastMul=0 -> EXEC; all other ops -> RESULT next cycle, with the state update (acc) applied on that edge.
- EXEC: 32-cycle shift-add (counter 31->0); acc updates on exit to RESULT. Commit-to-result_valid latency is 33 cycles; it is 1 cycle for all other cases.
- RESULT: result_valid_o=1; data and we stay stable until result_ready_i=1. Then IDLE next cycle; the next issue can be accepted the cycle after that.
- result_we_o equals the latched writeback. ACC_WR still returns a result with we=0 and data=0.

Optional Feature:
CVE2_XIF_COPRO_PERF_EN: adds a 32-bit wrapping committed-instruction counter (incremented on each non-killed commit) and decodes funct3 100 CNT_RD (read 000, wb 1, rd=counter value before this instruction's increment). Without the macro: no counter, and funct3 100 is rejected.

Decomposition:
- Package cve2_xif_copro_pkg: opcode constant, funct3 enum copro_op_e, state enum copro_state_e.
- Sub-module cve2_xif_copro_mul: iterative/fast multiplier with start/done, selected by FastMul.

Test Plan:
- ACC_WR rs1=5, commit, result ready=1 -> result valid 1 cycle after commit, we=0. Then MAC rs1=3, rs2=4 -> data=17, we=1. With FastMul=0, valid arrives 33 cycles after commit.
- Instr 32'h00000013 (addi) with valid=1 -> ready=1, accept=0; state stays IDLE; no result; immediate re-issue accepted.
- ADD3 with rs_valid=3'b011 for 3 cycles, then 3'b111 -> ready rises only in the 111 cycle. rs=1,2,0xFFFFFFFF -> data=2 (wrap).
- MAC issued then commit with kill=1 -> no result_valid; following ACC_RD returns the unchanged acc.
- result_ready_i held 0 for 10 cycles -> valid and data stable, ready=0 to new issues; on ready=1, IDLE next cycle.
- rst_ni asserted during EXEC -> all outputs 0 immediately; acc=AccResetVal. With PERF_EN, CNT_RD after 3 commits and 1 kill -> 3.
